alu_result_collector: RTL and testbench

- Receiving end of the ALU_64_bit result interface: captures Result, Zero and the issuing ALUOp tag into a small FIFO.
- Hands each entry to downstream writeback/compare logic over a valid/ready handshake.
- Keeps running statistics for datapath bring-up: accepted-op count, zero-result count, illegal-opcode flag and a 64-bit rotating-XOR signature of accepted results.
- Sits between ALU_64_bit and the register-file writeback / self-check logic.

---
 rtl/alu_result_collector.sv | 194 +++++++++++++++++++
 tb/tb_alu_result_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_collector.sv
// alu_result_collector: receives ALU_64_bit results into a small
// first-word-fall-through FIFO, hands them downstream over valid/ready,
// and keeps bring-up statistics (op/zero counters, illegal-op flag,
// rotating-XOR signature of accepted results).
module alu_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_result,
  input  logic             in_zero,
  input  logic [3:0]       in_aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_zero,
  output logic [3:0]       out_aluop,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] zero_count,
  output logic [63:0]      signature,
  output logic             err_illegal
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Opcodes the ALU is allowed to issue
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_NOR = 4'b1100
  } aluop_e;

  // FIFO storage
  logic [63:0]      res_mem_q  [DEPTH];
  logic             zero_mem_q [DEPTH];
  logic [3:0]       op_mem_q   [DEPTH];

  // Pointers and occupancy
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Last popped entry, shown on out_* while the FIFO is empty
  logic [63:0]      last_res_q;
  logic             last_zero_q;
  logic [3:0]       last_op_q;

  // Statistics
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [63:0]      sig_q, sig_d;
  logic             err_q, err_d;

  // Handshake decode
  logic             full, empty;
  logic             op_legal;
  logic             accept;
  logic             push;
  logic             pop;

  // Legal-opcode decode
  always_comb begin
    op_legal = 1'b0;
    unique case (in_aluop)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // An illegal op still completes the handshake; it just isn't stored
  assign accept = in_valid && in_ready;
  assign push   = accept && op_legal;
  assign pop    = out_valid && out_ready;

  // Head presentation: live entry when valid, otherwise the last one popped
  always_comb begin
    out_result = last_res_q;
    out_zero   = last_zero_q;
    out_aluop  = last_op_q;
    if (out_valid) begin
      out_result = res_mem_q[rd_ptr_q];
      out_zero   = zero_mem_q[rd_ptr_q];
      out_aluop  = op_mem_q[rd_ptr_q];
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Statistics next-state; clear wins over a same-cycle update
  always_comb begin
    op_cnt_d   = op_cnt_q;
    zero_cnt_d = zero_cnt_q;
    sig_d      = sig_q;
    err_d      = err_q;
    if (accept && !op_legal) begin
      err_d = 1'b1;
    end
    if (clr_stats) begin
      op_cnt_d   = '0;
      zero_cnt_d = '0;
      sig_d      = '0;
    end else if (push) begin
      sig_d = {sig_q[62:0], sig_q[63]} ^ in_result;
      if (op_cnt_q != '1) begin
        op_cnt_d = op_cnt_q + CNT_W'(1);
      end
      if (in_zero && (zero_cnt_q != '1)) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
  end

  // Control and statistics registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_cnt_q   <= '0;
      zero_cnt_q <= '0;
      sig_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_cnt_q   <= op_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      sig_q      <= sig_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage write at the tail
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_mem_q[i]  <= '0;
        zero_mem_q[i] <= 1'b0;
        op_mem_q[i]   <= '0;
      end
    end else if (push) begin
      res_mem_q[wr_ptr_q]  <= in_result;
      zero_mem_q[wr_ptr_q] <= in_zero;
      op_mem_q[wr_ptr_q]   <= in_aluop;
    end
  end

  // Capture the head as it leaves so out_* can hold it while empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_res_q  <= '0;
      last_zero_q <= 1'b0;
      last_op_q   <= '0;
    end else if (pop) begin
      last_res_q  <= res_mem_q[rd_ptr_q];
      last_zero_q <= zero_mem_q[rd_ptr_q];
      last_op_q   <= op_mem_q[rd_ptr_q];
    end
  end

  assign op_count    = op_cnt_q;
  assign zero_count  = zero_cnt_q;
  assign signature   = sig_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Testbench for alu_result_collector: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_alu_result_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_result = '0;
  logic             in_zero = 1'b0;
  logic [3:0]       in_aluop = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_result;
  logic             out_zero;
  logic [3:0]       out_aluop;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] zero_count;
  logic [63:0]      signature;
  logic             err_illegal;

  alu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_zero    (in_zero),
    .in_aluop   (in_aluop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_aluop  (out_aluop),
    .clr_stats  (clr_stats),
    .op_count   (op_count),
    .zero_count (zero_count),
    .signature  (signature),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic [63:0] r;
    logic        z;
    logic [3:0]  op;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_last;
  int unsigned m_ops;
  int unsigned m_zeros;
  logic [63:0] m_sig;
  bit          m_err;

  function automatic bit is_legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
           (op == 4'b0110) || (op == 4'b1100);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last.r = '0; m_last.z = 1'b0; m_last.op = '0;
    m_ops = 0; m_zeros = 0; m_sig = '0; m_err = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    ent_t e;
    e = (m_q.size() > 0) ? m_q[0] : m_last;
    check({ph, ".in_ready"},    in_ready,    m_q.size() < DEPTH);
    check({ph, ".out_valid"},   out_valid,   m_q.size() > 0);
    check({ph, ".out_result"},  out_result,  e.r);
    check({ph, ".out_zero"},    out_zero,    e.z);
    check({ph, ".out_aluop"},   out_aluop,   e.op);
    check({ph, ".op_count"},    op_count,    m_ops);
    check({ph, ".zero_count"},  zero_count,  m_zeros);
    check({ph, ".signature"},   signature,   m_sig);
    check({ph, ".err_illegal"}, err_illegal, m_err);
  endtask

  // One clock cycle: drive, check pre-edge state, advance model on the edge
  task automatic cycle(input string ph, input bit v, input logic [3:0] op,
                       input logic [63:0] r, input bit z, input bit rdy, input bit clr);
    bit   acc, pop;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_aluop = op; in_result = r; in_zero = z;
    out_ready = rdy; clr_stats = clr;
    #1;
    check_outputs(ph);
    acc = v && (m_q.size() < DEPTH);
    pop = rdy && (m_q.size() > 0);
    @(posedge clk);
    if (pop) begin
      m_last = m_q[0];
      void'(m_q.pop_front());
    end
    if (acc && is_legal(op)) begin
      e.r = r; e.z = z; e.op = op;
      m_q.push_back(e);
    end
    if (acc && !is_legal(op)) m_err = 1'b1;
    if (clr) begin
      m_ops = 0; m_zeros = 0; m_sig = '0;
    end else if (acc && is_legal(op)) begin
      m_sig = {m_sig[62:0], m_sig[63]} ^ r;
      if (m_ops < (1 << CNT_W) - 1) m_ops++;
      if (z && m_zeros < (1 << CNT_W) - 1) m_zeros++;
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
  endtask

  // Asynchronous reset in mid-cycle, checked before any clock edge
  task automatic apply_reset(input string ph);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(ph);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [3:0] legal_ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};

  initial begin
    model_reset();
    #1;
    check_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Single op with immediate drain
    cycle("single", 1'b1, 4'b0000, 64'h000000000000000F, 1'b0, 1'b1, 1'b0);
    check("single.vis_valid", out_valid, 1'b1);
    check("single.vis_result", out_result, 64'h000000000000000F);
    cycle("single_pop", 1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0);
    check("single.op_count", op_count, 16'd1);
    check("single.zero_count", zero_count, 16'd0);
    check("single.sig", signature, 64'h000000000000000F);
    check("single.empty", out_valid, 1'b0);
    check("single.hold", out_result, 64'h000000000000000F);

    // Fill to full with out_ready low
    apply_reset("rst_seq");
    cycle("seq", 1'b1, 4'b0000, 64'h000000000000000F, 1'b0, 1'b0, 1'b0);
    cycle("seq", 1'b1, 4'b0001, 64'h0002300AB0000F0F, 1'b0, 1'b0, 1'b0);
    check("seq.sig2", signature, 64'h0002300AB0000F11);
    cycle("seq", 1'b1, 4'b0010, 64'h0002300AB0000F1E, 1'b0, 1'b0, 1'b0);
    cycle("seq", 1'b1, 4'b0110, 64'hFFFDD00AAFFFF100, 1'b0, 1'b0, 1'b0);
    check("seq.full_ready", in_ready, 1'b0);
    // Full with simultaneous push/pop: only the pop happens, then NOR goes in
    cycle("full_pp", 1'b1, 4'b1100, 64'hFFFDCFF54FFFF0F0, 1'b0, 1'b1, 1'b0);
    check("full_pp.ready_back", in_ready, 1'b1);
    cycle("full_push", 1'b1, 4'b1100, 64'hFFFDCFF54FFFF0F0, 1'b0, 1'b1, 1'b0);
    drain("seq_drain", 4);
    check("seq.last_nor", out_aluop, 4'b1100);
    check("seq.empty", out_valid, 1'b0);

    // Zero result and illegal opcode
    apply_reset("rst_zi");
    cycle("zi", 1'b1, 4'b0110, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle("zi", 1'b1, 4'b0111, 64'h1234, 1'b0, 1'b0, 1'b0);
    check("zi.zero_count", zero_count, 16'd1);
    check("zi.op_count", op_count, 16'd1);
    check("zi.err", err_illegal, 1'b1);
    drain("zi_drain", 2);
    check("zi.only_sub", out_aluop, 4'b0110);

    // clr_stats with two entries queued
    cycle("clr", 1'b1, 4'b0010, 64'hAAAA5555AAAA5555, 1'b0, 1'b0, 1'b0);
    cycle("clr", 1'b1, 4'b0001, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0);
    cycle("clr_pulse", 1'b0, 4'b0000, '0, 1'b0, 1'b0, 1'b1);
    check("clr.op_count", op_count, 16'd0);
    check("clr.sig", signature, 64'h0);
    check("clr.err_kept", err_illegal, 1'b1);
    drain("clr_drain", 3);

    // Reset with three entries queued and err set
    cycle("mid", 1'b1, 4'b0010, 64'h11, 1'b0, 1'b0, 1'b0);
    cycle("mid", 1'b1, 4'b0010, 64'h22, 1'b1, 1'b0, 1'b0);
    cycle("mid", 1'b1, 4'b1111, 64'h33, 1'b0, 1'b0, 1'b0);
    cycle("mid", 1'b1, 4'b0001, 64'h44, 1'b0, 1'b0, 1'b0);
    apply_reset("rst_mid");
    cycle("post_rst", 1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [63:0] r;
      bit          v, z, rdy, clr;
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                        : legal_ops[$urandom_range(0, 4)];
      r   = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
      z   = (r == 64'h0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 63) == 0);
      if (i == 1500) apply_reset("rst_rand");
      cycle("rand", v, op, r, z, rdy, clr);
    end

    @(negedge clk);
    #1;
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
